npc_unit: RTL and testbench

- Next-generation fetch PC unit for the MIPS single-cycle/multi-cycle core; holds the architectural PC and computes the next fetch address every cycle.
- Generalises the basic +4/branch/jump/jr selector:
  - six conditional-branch conditions evaluated internally from register data;
  - fetch stall;
  - optional architectural branch delay slot;
  - exception entry with EPC capture, and ERET return.
- Sits between the instruction memory address port and the decode/control unit; the control unit drives selects, and the register file drives rs/rt data.

---
 rtl/npc_pkg.sv | 27 ++
 rtl/npc_unit_if.sv | 28 ++
 rtl/npc_unit_br_cond_eval.sv | 32 +++
 rtl/npc_unit.sv | 131 +++++++++++++
 tb/tb_npc_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared encodings for the next-PC unit and decode.
// Holds npc_sel / br_cond codes and the delay-slot states.
package npc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'b000,
        NPC_BR   = 3'b001,
        NPC_J    = 3'b010,
        NPC_JR   = 3'b011,
        NPC_ERET = 3'b100
    } npc_sel_e;

    typedef enum logic [2:0] {
        BC_BEQ  = 3'b000,
        BC_BNE  = 3'b001,
        BC_BLEZ = 3'b010,
        BC_BGTZ = 3'b011,
        BC_BLTZ = 3'b100,
        BC_BGEZ = 3'b101
    } br_cond_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SLOT = 1'b1
    } npc_state_e;

endpackage

// File: rtl/npc_unit_if.sv
// npc_unit_if: decode/regfile side <-> next-PC unit bundle.
// master = control side, slave = npc_unit.
interface npc_unit_if;
    logic        stall;
    logic [31:0] instr;
    logic [2:0]  npc_sel;
    logic [2:0]  br_cond;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        redirect;
    logic [31:0] epc;
    logic        exl;

    modport master (
        output stall, instr, npc_sel, br_cond,
        output rs_data, rt_data, exc_req,
        input  pc, link_addr, redirect, epc, exl
    );

    modport slave (
        input  stall, instr, npc_sel, br_cond,
        input  rs_data, rt_data, exc_req,
        output pc, link_addr, redirect, epc, exl
    );
endinterface

// File: rtl/npc_unit_br_cond_eval.sv
// br_cond_eval: signed branch condition evaluation.
// Unknown condition codes are never taken.
module br_cond_eval
    import npc_pkg::*;
(
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [2:0]  br_cond_i,
    output logic        taken_o
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_data_i[31];
    assign rs_zero = (rs_data_i == 32'd0);

    // Select the comparison named by br_cond.
    always_comb begin
        taken_o = 1'b0;
        case (br_cond_i)
            BC_BEQ:  taken_o = (rs_data_i == rt_data_i);
            BC_BNE:  taken_o = (rs_data_i != rt_data_i);
            BC_BLEZ: taken_o = rs_neg || rs_zero;
            BC_BGTZ: taken_o = !rs_neg && !rs_zero;
            BC_BLTZ: taken_o = rs_neg;
            BC_BGEZ: taken_o = !rs_neg;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/npc_unit.sv
// npc_unit: architectural PC, next-fetch selection,
// optional delay slot, exception entry and eret.
module npc_unit
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    npc_unit_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        exl_q, exl_d;
    npc_state_e  state_q, state_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] tgt;
    logic        take;
    logic        taken;
    logic        redir;
    logic [5:0]  unused_opcode;

    assign unused_opcode = bus.instr[31:26];

    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_plus4
                    + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
    assign jmp_tgt  = {pc_plus4[31:28], bus.instr[25:0], 2'b00};
    assign jr_tgt   = {bus.rs_data[31:2], 2'b00};

    br_cond_eval u_br_cond_eval (
        .rs_data_i (bus.rs_data),
        .rt_data_i (bus.rt_data),
        .br_cond_i (bus.br_cond),
        .taken_o   (taken)
    );

    // Pick the redirect target and whether it is taken.
    always_comb begin
        tgt  = pc_plus4;
        take = 1'b0;
        case (bus.npc_sel)
            NPC_BR: begin
                tgt  = br_tgt;
                take = taken;
            end
            NPC_J: begin
                tgt  = jmp_tgt;
                take = 1'b1;
            end
            NPC_JR: begin
                tgt  = jr_tgt;
                take = 1'b1;
            end
            default: begin
                tgt  = pc_plus4;
                take = 1'b0;
            end
        endcase
    end

    // Next-state: exception > stall > slot > eret > redirect > seq.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        exl_d   = exl_q;
        tgt_d   = tgt_q;
        state_d = state_q;
        redir   = 1'b0;
        if (bus.exc_req && !exl_q) begin
            epc_d   = (state_q == ST_SLOT) ? pc_q - 32'd4 : pc_q;
            pc_d    = EXC_VECTOR;
            exl_d   = 1'b1;
            state_d = ST_RUN;
            redir   = 1'b1;
        end else if (bus.stall) begin
            redir = 1'b0;
        end else if (state_q == ST_SLOT) begin
            pc_d    = tgt_q;
            state_d = ST_RUN;
            redir   = 1'b1;
        end else if (bus.npc_sel == NPC_ERET) begin
            pc_d  = epc_q;
            exl_d = 1'b0;
            redir = 1'b1;
        end else if (take) begin
            if (DELAY_SLOT) begin
                tgt_d   = tgt;
                state_d = ST_SLOT;
                pc_d    = pc_plus4;
            end else begin
                pc_d  = tgt;
                redir = 1'b1;
            end
        end else begin
            pc_d = pc_plus4;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            exl_q   <= 1'b0;
            tgt_q   <= 32'd0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            exl_q   <= exl_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.epc       = epc_q;
    assign bus.exl       = exl_q;
    assign bus.redirect  = redir;
    assign bus.link_addr = pc_q + (DELAY_SLOT ? 32'd8 : 32'd4);

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed + random check of npc_unit
// (both delay-slot variants) against a behavioural model.
module tb_npc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] tgt;
        logic        exl;
        logic        pend;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  sel = '0;
    logic [2:0]  cond = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        exc = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    mstate_t m0, m1;
    logic        rd_s0, rd_s1;
    logic [31:0] lk_s0, lk_s1;

    npc_unit_if if0 ();
    npc_unit_if if1 ();

    assign if0.stall = stall;   assign if1.stall = stall;
    assign if0.instr = instr;   assign if1.instr = instr;
    assign if0.npc_sel = sel;   assign if1.npc_sel = sel;
    assign if0.br_cond = cond;  assign if1.br_cond = cond;
    assign if0.rs_data = rs;    assign if1.rs_data = rs;
    assign if0.rt_data = rt;    assign if1.rt_data = rt;
    assign if0.exc_req = exc;   assign if1.exc_req = exc;

    npc_unit #(.DELAY_SLOT(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    npc_unit #(.DELAY_SLOT(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic bit cond_true();
        int signed a;
        int signed b;
        a = int'(rs);
        b = int'(rt);
        case (cond)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return a <= 0;
            3'd3: return a > 0;
            3'd4: return a < 0;
            3'd5: return a >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic mstate_t mnext(mstate_t s, bit ds,
                                      output logic rd);
        mstate_t     n;
        logic [31:0] t;
        bit          go;
        int signed   off;
        n   = s;
        rd  = 1'b0;
        off = int'($signed(instr[15:0])) * 4;
        t   = 32'(s.pc + 4);
        go  = 1'b0;
        if (sel == 3'd1 && cond_true()) begin
            t  = 32'(s.pc + 4 + off);
            go = 1'b1;
        end else if (sel == 3'd2) begin
            t  = ((s.pc + 4) & 32'hF000_0000)
               | (32'(instr[25:0]) * 4);
            go = 1'b1;
        end else if (sel == 3'd3) begin
            t  = rs & 32'hFFFF_FFFC;
            go = 1'b1;
        end
        if (exc && !s.exl) begin
            n.epc  = s.pend ? s.pc - 4 : s.pc;
            n.pc   = EXC_PC;
            n.exl  = 1'b1;
            n.pend = 1'b0;
            rd     = 1'b1;
        end else if (stall) begin
            rd = 1'b0;
        end else if (s.pend) begin
            n.pc   = s.tgt;
            n.pend = 1'b0;
            rd     = 1'b1;
        end else if (sel == 3'd4) begin
            n.pc  = s.epc;
            n.exl = 1'b0;
            rd    = 1'b1;
        end else if (go && ds) begin
            n.tgt  = t;
            n.pend = 1'b1;
            n.pc   = s.pc + 4;
        end else if (go) begin
            n.pc = t;
            rd   = 1'b1;
        end else begin
            n.pc = s.pc + 4;
        end
        return n;
    endfunction

    task automatic cyc();
        mstate_t n0, n1;
        logic    r0, r1;
        @(negedge clk);
        n0 = mnext(m0, 1'b0, r0);
        n1 = mnext(m1, 1'b1, r1);
        rd_s0 = if0.redirect;
        rd_s1 = if1.redirect;
        lk_s0 = if0.link_addr;
        lk_s1 = if1.link_addr;
        chk("redir0", {31'b0, rd_s0}, {31'b0, r0});
        chk("redir1", {31'b0, rd_s1}, {31'b0, r1});
        chk("link0", lk_s0, m0.pc + 32'd4);
        chk("link1", lk_s1, m1.pc + 32'd8);
        @(posedge clk);
        #1;
        m0 = n0;
        m1 = n1;
        chk("pc0", if0.pc, m0.pc);
        chk("pc1", if1.pc, m1.pc);
        chk("epc0", if0.epc, m0.epc);
        chk("epc1", if1.epc, m1.epc);
        chk("exl0", {31'b0, if0.exl}, {31'b0, m0.exl});
        chk("exl1", {31'b0, if1.exl}, {31'b0, m1.exl});
    endtask

    task automatic idle();
        stall = 1'b0;
        exc   = 1'b0;
        sel   = 3'd0;
        cond  = 3'd0;
        instr = '0;
        rs    = '0;
        rt    = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m0 = '{pc: RST_PC, epc: 32'd0, tgt: 32'd0,
               exl: 1'b0, pend: 1'b0};
        m1 = m0;
    endtask

    task automatic go_seq(int n);
        do_reset();
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        do_reset();
        chk("rst_pc0", if0.pc, 32'h3000);
        chk("rst_pc1", if1.pc, 32'h3000);
        chk("rst_epc", if1.epc, 32'h0);
        chk("rst_exl", {31'b0, if1.exl}, 32'd0);
        cyc(); chk("run1", if0.pc, 32'h3004);
        cyc(); chk("run2", if0.pc, 32'h3008);
        cyc(); chk("run3", if0.pc, 32'h300C);

        go_seq(4);
        sel = 3'd1; cond = 3'd0; rs = 32'd5; rt = 32'd5;
        instr = 32'h0000_FFFC;
        cyc();
        chk("beq_tk_pc", if0.pc, 32'h3004);
        chk("beq_tk_rd", {31'b0, rd_s0}, 32'd1);

        go_seq(4);
        sel = 3'd1; cond = 3'd0; rs = 32'd5; rt = 32'd6;
        instr = 32'h0000_FFFC;
        cyc();
        chk("beq_nt_pc", if0.pc, 32'h3014);

        go_seq(4);
        sel = 3'd1; cond = 3'd5; rs = 32'h8000_0000;
        instr = 32'h0000_FFFC;
        cyc();
        chk("bgez_nt_pc", if0.pc, 32'h3014);

        do_reset();
        sel = 3'd2; instr = 32'h0C00_0C40;
        cyc();
        chk("jal_link", lk_s0, 32'h3004);
        chk("jal_pc", if0.pc, 32'h3100);
        sel = 3'd3; rs = 32'h0000_3203;
        cyc();
        chk("jr_pc", if0.pc, 32'h3200);

        do_reset();
        sel = 3'd2; instr = 32'h0800_0C40;
        cyc();
        chk("ds_j_slot", if1.pc, 32'h3004);
        idle();
        cyc();
        chk("ds_j_tgt", if1.pc, 32'h3100);

        do_reset();
        sel = 3'd2; instr = 32'h0800_0C40;
        cyc();
        idle(); stall = 1'b1;
        cyc(); chk("ds_stall1", if1.pc, 32'h3004);
        cyc(); chk("ds_stall2", if1.pc, 32'h3004);
        stall = 1'b0;
        cyc(); chk("ds_stall_tgt", if1.pc, 32'h3100);

        do_reset();
        sel = 3'd2; instr = 32'h0800_0C40;
        cyc();
        idle(); exc = 1'b1;
        cyc();
        chk("exc_epc", if1.epc, 32'h3000);
        chk("exc_pc", if1.pc, 32'h4180);
        chk("exc_exl", {31'b0, if1.exl}, 32'd1);
        cyc();
        chk("exc2_epc", if1.epc, 32'h3000);
        chk("exc2_exl", {31'b0, if1.exl}, 32'd1);
        exc = 1'b0; sel = 3'd4;
        cyc();
        chk("eret_pc", if1.pc, 32'h3000);
        chk("eret_exl", {31'b0, if1.exl}, 32'd0);

        do_reset();
        exc = 1'b1;
        cyc();
        exc = 1'b0; sel = 3'd2; instr = 32'h0800_0C40;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", if1.pc, 32'h3000);
        chk("arst_exl", {31'b0, if1.exl}, 32'd0);
        chk("arst_epc", if1.epc, 32'h0);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            exc   = ($urandom_range(0, 15) == 0);
            sel   = 3'($urandom_range(0, 7));
            cond  = 3'($urandom_range(0, 7));
            instr = $urandom;
            case ($urandom_range(0, 4))
                0: rs = 32'd0;
                1: rs = 32'd1;
                2: rs = 32'hFFFF_FFFF;
                3: rs = 32'h8000_0000;
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
